// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: operation codes, FSM states, flag bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_MUL = 2'b01,
    ALU_DIV = 2'b10,
    ALU_RSV = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between the decoder (master) and the ALU sequencer (slave).
interface alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       aluControl;
  logic             flagUpdate;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             ready;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, aluControl, flagUpdate, srcA, srcB,
    input  ready, stall, done, result, flags
  );

  modport slave (
    input  start, aluControl, flagUpdate, srcA, srcB,
    output ready, stall, done, result, flags
  );
endinterface

// File: rtl/alu_sequencer_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the remainder and subtract when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  // One extra bit: the shifted remainder can exceed WIDTH bits before the subtract.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted  = {rem, next_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle add/mul/div sequencer with registered result, NZCV flags and a done pulse.
// Optional ALU_SEQ_EARLY_EXIT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg, mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [WIDTH-1:0]   dq_reg;       // dividend shifts out the top, quotient shifts in the bottom
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic               fu_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [3:0]         flags_reg;

  alu_op_t            op_in;
  logic               accept;
  logic [WIDTH:0]     add_sum;
  logic               add_v;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_shift;
  logic               mul_last;
  logic               div_last;
  logic [WIDTH-1:0]   rem_step;
  logic               q_bit;

  logic               fin_load;
  logic               fin_upd;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_c;
  logic               fin_v;
  logic [3:0]         fin_flags;

  assign op_in  = alu_op_t'(bus.aluControl);
  assign accept = (state_reg == ST_IDLE) && bus.start;

  assign add_sum = {1'b0, bus.srcA} + {1'b0, bus.srcB};
  assign add_v   = (bus.srcA[WIDTH-1] == bus.srcB[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != bus.srcA[WIDTH-1]);

  assign acc_step     = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign mplier_shift = mplier_reg >> 1;

`ifdef ALU_SEQ_EARLY_EXIT_EN
  assign mul_last = (count_reg == CW'(1)) || (mplier_shift == '0);
`else
  assign mul_last = (count_reg == CW'(1));
`endif
  assign div_last = (count_reg == CW'(1));

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem_reg),
    .divisor  (divisor_reg),
    .next_bit (dq_reg[WIDTH-1]),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          case (op_in)
            ALU_MUL: state_next = ST_MUL;
            ALU_DIV: state_next = (bus.srcB == '0) ? ST_DONE : ST_DIV;
            default: state_next = ST_DONE;
          endcase
        end
      end
      ST_MUL:  if (mul_last) state_next = ST_DONE;
      ST_DIV:  if (div_last) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.ready = 1'b0;
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.ready = 1'b1;
        bus.stall = bus.start && ((op_in == ALU_MUL) || (op_in == ALU_DIV));
      end
      ST_MUL, ST_DIV: bus.stall = 1'b1;
      default:        bus.done  = 1'b1;
    endcase
  end

  assign bus.result = result_reg;
  assign bus.flags  = flags_reg;

  // Result and flag values to capture on the edge that enters DONE
  always_comb begin
    fin_load   = 1'b0;
    fin_upd    = 1'b0;
    fin_result = '0;
    fin_c      = 1'b0;
    fin_v      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          case (op_in)
            ALU_ADD: begin
              fin_load   = 1'b1;
              fin_upd    = bus.flagUpdate;
              fin_result = add_sum[WIDTH-1:0];
              fin_c      = add_sum[WIDTH];
              fin_v      = add_v;
            end
            ALU_DIV: begin
              if (bus.srcB == '0) begin
                fin_load   = 1'b1;
                fin_upd    = bus.flagUpdate;
                fin_result = '1;
                fin_v      = 1'b1;
              end
            end
            ALU_RSV: fin_load = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          fin_load   = 1'b1;
          fin_upd    = fu_reg;
          fin_result = acc_step[WIDTH-1:0];
          fin_c      = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
      ST_DIV: begin
        if (div_last) begin
          fin_load   = 1'b1;
          fin_upd    = fu_reg;
          fin_result = {dq_reg[WIDTH-2:0], q_bit};
        end
      end
      default: ;
    endcase
    fin_flags         = '0;
    fin_flags[FLAG_N] = fin_result[WIDTH-1];
    fin_flags[FLAG_Z] = (fin_result == '0);
    fin_flags[FLAG_C] = fin_c;
    fin_flags[FLAG_V] = fin_v;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      dq_reg      <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      fu_reg      <= 1'b0;
      result_reg  <= '0;
      flags_reg   <= '0;
    end else begin
      if (accept) begin
        count_reg   <= CW'(WIDTH);
        acc_reg     <= '0;
        mcand_reg   <= {{WIDTH{1'b0}}, bus.srcA};
        mplier_reg  <= bus.srcB;
        dq_reg      <= bus.srcA;
        rem_reg     <= '0;
        divisor_reg <= bus.srcB;
        fu_reg      <= bus.flagUpdate;
      end else if (state_reg == ST_MUL) begin
        count_reg  <= count_reg - CW'(1);
        acc_reg    <= acc_step;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_shift;
      end else if (state_reg == ST_DIV) begin
        count_reg <= count_reg - CW'(1);
        rem_reg   <= rem_step;
        dq_reg    <= {dq_reg[WIDTH-2:0], q_bit};
      end
      if (fin_load) begin
        result_reg <= fin_result;
        if (fin_upd) flags_reg <= fin_flags;
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller sitting between the instruction decoder and the ALU write-back path. Accepts one operation per request (add, multiply, divide) selected by `aluControl`, runs single-cycle add directly and sequences iterative shift-add multiply and restoring divide one bit per cycle. Stalls the pipeline while busy, then presents a registered result and NZCV flags with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥4)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  operation request from decode
- `aluControl`  in  2  00 add, 01 mul, 10 div, 11 reserved
- `flagUpdate`  in  1  flags written at completion when high
- `srcA`  in  WIDTH  operand A (multiplicand / dividend)
- `srcB`  in  WIDTH  operand B (multiplier / divisor)
- `ready`  out  1  high only in IDLE; request accepted when `start && ready`
- `stall`  out  1  pipeline hold
- `done`  out  1  one-cycle completion pulse
- `result`  out  WIDTH  registered result, held until next completion
- `flags`  out  4  {N,Z,C,V}, registered, held

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: on accept, latch operands, `aluControl`, `flagUpdate`. Add → DONE with sum. Mul → MUL, count=WIDTH. Div with `srcB`≠0 → DIV, count=WIDTH. Div with `srcB`=0 → DONE, result all-ones, V=1. Reserved 11 → DONE, result 0, flags untouched regardless of `flagUpdate`.
- MUL (unsigned): per cycle, if multiplier[0] then acc += multiplicand (2·WIDTH-bit acc); multiplicand <<1; multiplier >>1; count−1. count reaches 0 → DONE.
- DIV (unsigned, restoring): per cycle, shift remainder left bringing in next dividend MSB; if rem ≥ divisor, subtract and set quotient bit. count reaches 0 → DONE. Result = quotient; remainder discarded.
- DONE: `done`=1, `result`/`flags` already loaded on the transition into DONE; next cycle → IDLE.
- Flags (loaded only if latched `flagUpdate`): N=result[WIDTH-1]; Z=(result==0). Add: C=carry-out, V=signed overflow. Mul: C=(upper WIDTH product bits ≠0), V=0. Div: C=0, V=divide-by-zero.
- `start` while not IDLE ignored; operands not re-sampled.
- `stall` = (IDLE && `start` && op∈{mul,div}) || MUL || DIV. Low in DONE and for add.
- Reset (any time, incl. mid-operation): state IDLE, `result`=0, `flags`=0, `done`=0, `stall`=0, `ready`=1 once IDLE; aborted operation produces no `done`.

## Timing
- Accept at edge T. Add, div-by-zero, reserved: `done` in cycle T+1.
- Mul/div: WIDTH cycles in MUL/DIV, `done` in cycle T+WIDTH+1.
- Back-to-back: next accept no earlier than cycle after DONE (throughput add = 1 per 2 cycles).
- `result`/`flags` change only on the edge entering DONE.

## Configuration
- `ALU_SEQ_EARLY_EXIT_EN` defined: MUL also exits to DONE when the multiplier after this cycle's shift is zero; latency = max(1, bit-length of `srcB`) MUL cycles; result identical.
- Undefined: MUL always WIDTH cycles. DIV latency fixed in both builds.

## Structure
- Package `alu_pkg`: `aluControl` encodings (ALU_ADD, ALU_MUL, ALU_DIV, ALU_RSV), state enum, flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module `div_step`: combinational single restoring-divide step (rem, divisor, next bit → new rem, quotient bit). Mul step and FSM inline.

## Test plan (WIDTH=32)
- Add 0x7FFFFFFF+0x00000001, `flagUpdate`=1 → `done` at T+1, result 0x80000000, NZCV=1001, `stall` never high.
- Mul 7×6 → result 42, NZCV=0000, `done` at T+33, `stall` high T..T+32; with `ALU_SEQ_EARLY_EXIT_EN`, `done` at T+4.
- Mul 0x00010000×0x00010000 → result 0, NZCV=0110; div 100÷7 → result 14, `done` at T+33.
- Div 5÷0 → `done` at T+1, result 0xFFFFFFFF, NZCV=1001; then add 1+1 with `flagUpdate`=0 → result 2, flags still 1001.
- `start` pulsed with new operands during MUL → ignored, original product returned, single `done`.
- `rst` asserted at T+10 of a mul → outputs zero immediately, no `done`; new add accepted after release completes normally.
